// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus handshake FSM feeding a UART transmitter's data_in/start.
// Define UART_TXBUF_OVERFLOW_EN to build the sticky write-when-full overflow flag.
module uart_tx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        WAIT_DONE
    } state_e;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    state_e                state_q, state_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  wr_accept;
    logic                  pop;

    assign full     = (count_q == COUNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

    // Writes are judged against the pre-edge full flag, so a write on a pop edge while full is dropped.
    assign wr_accept = wr_en && !full;

    // Handshake FSM: present the head byte, hold it until busy is seen, then wait for the
    // transmitter to finish before looking at the FIFO again.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_start_d = 1'b0;
                if (!empty) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ, WAIT_ACK: begin
                if (tx_busy) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_start_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_TXBUF_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // Sticky: only reset clears it.
    assign overflow_d = overflow_q | (wr_en & full);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a simple transmitter model that asserts busy
// for 20 cycles after it sees tx_start.
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       overflow;

    int errors = 0;
    int checks = 0;

`ifdef UART_TXBUF_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    uart_tx_buffer #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Transmitter model: works on the falling edge so its busy output is settled before the DUT's edge.
    bit         model_en = 1'b0;
    int         busy_cnt = 0;
    bit         saw_low = 1'b1;
    int         gap_errs = 0;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        if (!tx_start) saw_low = 1'b1;
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end else if (model_en && tx_start) begin
            if (!saw_low) gap_errs = gap_errs + 1;
            saw_low = 1'b0;
            rx_q.push_back(tx_data);
            tx_busy  = 1'b1;
            busy_cnt = 20;
        end
    end

    task automatic set_model(input bit en);
        @(posedge clk);
        #1 model_en = en;
    endtask

    task automatic push_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int n, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (rx_q.size() >= n && !tx_busy && empty && !tx_start) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout: received %0d bytes, required %0d", rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty: got %b exp 1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_full: got %b exp 0", full); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b exp 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h exp 00", tx_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b exp 0", overflow); end
        resetN = 1'b1;
    endtask

    task automatic test_single_byte();
        set_model(1'b1);
        rx_q.delete();
        push_burst(8'hA5, 1);
        checks++; if (count !== 5'd1)    begin errors++; $display("FAIL single_count_after_wr: got %0d exp 1", count); end
        checks++; if (empty !== 1'b0)    begin errors++; $display("FAIL single_empty_after_wr: got %b exp 0", empty); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b exp 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b exp 1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h exp a5", tx_data); end
        checks++; if (count !== 5'd1)    begin errors++; $display("FAIL single_count_req: got %0d exp 1", count); end
        @(negedge clk);
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL single_pop_count: got %0d exp 0", count); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL single_pop_empty: got %b exp 1", empty); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_drop: got %b exp 0", tx_start); end
        wait_drain(1, 200);
        checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'hA5)
            begin errors++; $display("FAIL single_rx: got %0d bytes first %h exp 1 byte a5", rx_q.size(), rx_q[0]); end
    endtask

    task automatic test_fill();
        set_model(1'b0);
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) begin
                checks++; if (count !== 5'd15 || full !== 1'b0)
                    begin errors++; $display("FAIL fill_15: count %0d full %b exp 15 0", count, full); end
            end
            wr_en   = 1'b1;
            wr_data = 8'(i + 1);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (count !== 5'd16)   begin errors++; $display("FAIL fill_count: got %0d exp 16", count); end
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fill_full: got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow: got %b exp 0", overflow); end
    endtask

    task automatic test_overflow();
        push_burst(8'hFF, 1);
        checks++; if (count !== 5'd16)      begin errors++; $display("FAIL ovf_count: got %0d exp 16", count); end
        checks++; if (full !== 1'b1)        begin errors++; $display("FAIL ovf_full: got %b exp 1", full); end
        checks++; if (overflow !== OVF_EXP) begin errors++; $display("FAIL ovf_flag: got %b exp %b", overflow, OVF_EXP); end
        repeat (3) @(negedge clk);
        checks++; if (overflow !== OVF_EXP) begin errors++; $display("FAIL ovf_sticky: got %b exp %b", overflow, OVF_EXP); end
    endtask

    task automatic test_hold_busy_low();
        int bad_start = 0, bad_data = 0, bad_count = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b1) bad_start++;
            if (tx_data !== 8'h01) bad_data++;
            if (count !== 5'd16)   bad_count++;
        end
        checks++; if (bad_start !== 0) begin errors++; $display("FAIL hold_start: %0d cycles low, exp 0", bad_start); end
        checks++; if (bad_data !== 0)  begin errors++; $display("FAIL hold_data: %0d cycles not 01, exp 0", bad_data); end
        checks++; if (bad_count !== 0) begin errors++; $display("FAIL hold_count: %0d cycles not 16, exp 0", bad_count); end
    endtask

    task automatic test_drain_order();
        set_model(1'b1);
        wait_drain(16, 2000);
        checks++; if (rx_q.size() !== 16) begin errors++; $display("FAIL drain_size: got %0d exp 16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(i + 1))
                begin errors++; $display("FAIL drain_byte%0d: got %h exp %h", i, rx_q[i], 8'(i + 1)); end
        end
        checks++; if (gap_errs !== 0) begin errors++; $display("FAIL start_gap: %0d bytes without gap, exp 0", gap_errs); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b;
        set_model(1'b0);
        rx_q.delete();
        push_burst(8'h31, 3);
        checks++; if (count !== 5'd3 || tx_start !== 1'b1 || tx_data !== 8'h31)
            begin errors++; $display("FAIL b2b_setup: count %0d start %b data %h exp 3 1 31", count, tx_start, tx_data); end
        set_model(1'b1);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h34;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (count !== 5'd3)    begin errors++; $display("FAIL b2b_count: got %0d exp 3", count); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL b2b_popped: start %b exp 0", tx_start); end
        wait_drain(4, 500);
        checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL b2b_size: got %0d exp 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            exp_b = 8'h31 + 8'(i);
            checks++; if (rx_q[i] !== exp_b)
                begin errors++; $display("FAIL b2b_byte%0d: got %h exp %h", i, rx_q[i], exp_b); end
        end
    endtask

    task automatic test_reset_mid_transfer();
        int starts = 0;
        rx_q.delete();
        push_burst(8'h41, 6);
        checks++; if (count !== 5'd5 || tx_start !== 1'b0 || tx_busy !== 1'b1)
            begin errors++; $display("FAIL mid_setup: count %0d start %b busy %b exp 5 0 1", count, tx_start, tx_busy); end
        resetN = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_rst_start: got %b exp 0", tx_start); end
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL mid_rst_count: got %0d exp 0", count); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL mid_rst_empty: got %b exp 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_overflow: got %b exp 0", overflow); end
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        checks++; if (starts !== 0)       begin errors++; $display("FAIL mid_no_resend: start high %0d cycles exp 0", starts); end
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL mid_rx_size: got %0d exp 1", rx_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill();
        test_overflow();
        test_hold_busy_low();
        test_drain_order();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
